// File: rtl/afu_port_flr_seq.sv
// Per-port FLR sequencer: gate new TX packets at a boundary, drain, hold port reset, pulse done.
// Optional drain watchdog enabled by defining AFU_PORT_FLR_TIMEOUT_EN.
module afu_port_flr_seq #(
  parameter int NUM_PORTS     = 4,
  parameter int RST_HOLD_CYC  = 16,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   port_flr_req,
  input  logic [NUM_PORTS-1:0]   afu_tx_tvalid,
  input  logic [NUM_PORTS-1:0]   afu_tx_tlast,
  output logic [NUM_PORTS-1:0]   afu_tx_tready,
  output logic [NUM_PORTS-1:0]   mux_tx_tvalid,
  input  logic [NUM_PORTS-1:0]   mux_tx_tready,
  output logic [NUM_PORTS-1:0]   port_rst_n,
  output logic [NUM_PORTS-1:0]   flr_done,
  output logic [NUM_PORTS-1:0]   drain_timeout_err,
  output logic [2*NUM_PORTS-1:0] dbg_state_o
);

  // TX handshake: a beat transfers on afu_tx_tvalid & afu_tx_tready; tvalid is never
  // forced by this block, only masked while a port is gated between packets.

  localparam int CNT_MAX = (RST_HOLD_CYC > DRAIN_TIMEOUT) ? RST_HOLD_CYC : DRAIN_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(RST_HOLD_CYC);
`ifdef AFU_PORT_FLR_TIMEOUT_EN
  localparam logic [CW-1:0] DRAIN_LIMIT = CW'(DRAIN_TIMEOUT);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_pkt_q, in_pkt_d, in_pkt_hs;
    logic          gate_q, gate_eff, hs;
    logic          rst_n_q, done_q;
    // Power-on hold returns to IDLE without a completion pulse.
    logic          por_q, por_d;

    assign gate_eff         = gate_q & ~in_pkt_q;
    assign mux_tx_tvalid[p] = afu_tx_tvalid[p] & ~gate_eff;
    assign afu_tx_tready[p] = mux_tx_tready[p] & ~gate_eff;
    assign hs               = afu_tx_tvalid[p] & afu_tx_tready[p];
    assign in_pkt_hs        = hs ? ~afu_tx_tlast[p] : in_pkt_q;

    assign port_rst_n[p]          = rst_n_q;
    assign flr_done[p]            = done_q;
    assign dbg_state_o[2*p +: 2]  = state_q;

`ifdef AFU_PORT_FLR_TIMEOUT_EN
    logic err_q, err_d;
    assign drain_timeout_err[p] = err_q;
`else
    assign drain_timeout_err[p] = 1'b0;
`endif

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      in_pkt_d = in_pkt_hs;
      por_d    = por_q;
`ifdef AFU_PORT_FLR_TIMEOUT_EN
      err_d    = err_q;
`endif
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (port_flr_req[p]) begin
            // Decide on the post-handshake packet state so a tlast this cycle skips DRAIN.
            if (in_pkt_hs) begin
              state_d = DRAIN;
              cnt_d   = CW'(1);
            end else begin
              state_d = HOLD;
              cnt_d   = HOLD_LOAD;
            end
          end
        end
        DRAIN: begin
          if (!in_pkt_hs) begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
`ifdef AFU_PORT_FLR_TIMEOUT_EN
          else if (cnt_q >= DRAIN_LIMIT) begin
            state_d  = HOLD;
            cnt_d    = HOLD_LOAD;
            in_pkt_d = 1'b0;
            err_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
        HOLD: begin
          if (cnt_q <= CW'(1)) begin
            state_d = por_q ? IDLE : DONE;
            por_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= HOLD;
        cnt_q    <= HOLD_LOAD;
        in_pkt_q <= 1'b0;
        gate_q   <= 1'b1;
        rst_n_q  <= 1'b0;
        done_q   <= 1'b0;
        por_q    <= 1'b1;
`ifdef AFU_PORT_FLR_TIMEOUT_EN
        err_q    <= 1'b0;
`endif
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        in_pkt_q <= in_pkt_d;
        gate_q   <= (state_d == DRAIN) || (state_d == HOLD);
        rst_n_q  <= (state_d != HOLD);
        done_q   <= (state_d == DONE);
        por_q    <= por_d;
`ifdef AFU_PORT_FLR_TIMEOUT_EN
        err_q    <= err_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_afu_port_flr_seq.sv
// Directed bench for afu_port_flr_seq: per-cycle model comparison plus literal latency checks.
module tb_afu_port_flr_seq;
  localparam int NP   = 4;
  localparam int HOLD = 16;
`ifdef AFU_PORT_FLR_TIMEOUT_EN
  localparam int DTO  = 8;
`else
  localparam int DTO  = 1024;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0] req, tvalid, tlast, mux_tready;
  logic [NP-1:0] afu_tready, mux_tvalid, prst_n, done, err;
  logic [2*NP-1:0] dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  afu_port_flr_seq #(
    .NUM_PORTS    (NP),
    .RST_HOLD_CYC (HOLD),
    .DRAIN_TIMEOUT(DTO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .port_flr_req     (req),
    .afu_tx_tvalid    (tvalid),
    .afu_tx_tlast     (tlast),
    .afu_tx_tready    (afu_tready),
    .mux_tx_tvalid    (mux_tvalid),
    .mux_tx_tready    (mux_tready),
    .port_rst_n       (prst_n),
    .flr_done         (done),
    .drain_timeout_err(err),
    .dbg_state_o      (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: remaining reset-hold cycles, draining flag, packet-open flag, pending done.
  int m_hold[NP];
  int m_dcnt[NP];
  bit m_drain[NP], m_in[NP], m_done[NP], m_por[NP], m_err[NP];

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_hold[p] = HOLD; m_dcnt[p] = 0; m_drain[p] = 0;
      m_in[p] = 0; m_done[p] = 0; m_por[p] = 1; m_err[p] = 0;
    end
  endtask

  function automatic bit m_geff(int p);
    return (m_drain[p] || m_hold[p] > 0) && !m_in[p];
  endfunction

  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      bit hs, nxt;
      hs  = tvalid[p] && mux_tready[p] && !m_geff(p);
      nxt = hs ? !tlast[p] : m_in[p];
      m_done[p] = 0;
      if (m_hold[p] > 0) begin
        m_hold[p]--;
        if (m_hold[p] == 0) begin
          m_done[p] = !m_por[p];
          m_por[p]  = 0;
        end
      end else if (m_drain[p]) begin
        if (!nxt) begin
          m_drain[p] = 0; m_hold[p] = HOLD;
        end
`ifdef AFU_PORT_FLR_TIMEOUT_EN
        else if (m_dcnt[p] >= DTO) begin
          m_drain[p] = 0; m_hold[p] = HOLD; nxt = 0; m_err[p] = 1;
        end else begin
          m_dcnt[p]++;
        end
`endif
      end else if (req[p]) begin
        if (nxt) begin
          m_drain[p] = 1; m_dcnt[p] = 1;
        end else begin
          m_hold[p] = HOLD;
        end
      end
      m_in[p] = nxt;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    for (int p = 0; p < NP; p++) begin
      logic [4:0] act, exp;
      act = {afu_tready[p], mux_tvalid[p], prst_n[p], done[p], err[p]};
      exp = {mux_tready[p] & !m_geff(p), tvalid[p] & !m_geff(p),
             logic'(m_hold[p] == 0), m_done[p], m_err[p]};
      check($sformatf("port%0d_outs", p), 32'(act), 32'(exp));
    end
    if (rst_n) model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int first, second, third;
    req = '0; tvalid = '0; tlast = '0; mux_tready = '1;
    repeat (3) tick();
    tvalid = '1;
    #1;
    check("reset_rst_n", 32'(prst_n), 32'(4'h0));
    check("reset_done", 32'(done), 32'(4'h0));
    check("reset_err", 32'(err), 32'(4'h0));
    check("reset_gated_tvalid", 32'(mux_tvalid), 32'(4'h0));
    tvalid = '0;

    // Power-on hold
    rst_n = 1'b1;
    repeat (15) tick();
    check("por_rst_cyc15", 32'(prst_n), 32'(4'h0));
    tick();
    check("por_rst_released", 32'(prst_n), 32'(4'hf));
    check("por_no_done", 32'(done), 32'(4'h0));
    repeat (3) tick();

    // Idle FLR on port 1
    req[1] = 1'b1;
    tick();
    req = '0;
    check("flr1_rst_t1", 32'(prst_n), 32'(4'b1101));
    repeat (15) tick();
    check("flr1_rst_t16", 32'(prst_n), 32'(4'b1101));
    check("flr1_nodone_t16", 32'(done), 32'(4'h0));
    tick();
    check("flr1_rst_t17", 32'(prst_n), 32'(4'hf));
    check("flr1_done_t17", 32'(done), 32'(4'b0010));
    tick();
    check("flr1_done_t18", 32'(done), 32'(4'h0));

    // Mid-packet FLR on port 0
    tvalid[0] = 1'b1; tlast[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    req = '0;
    #1;
    check("pkt_beat3_ready", 32'(afu_tready[0]), 32'd1);
    check("pkt_beat3_not_rst", 32'(prst_n[0]), 32'd1);
    tick();
    tlast[0] = 1'b1;
    #1;
    check("pkt_beat4_ready", 32'(afu_tready[0]), 32'd1);
    tick();
    tlast[0] = 1'b0;
    #1;
    check("pkt_sop_blocked", 32'(mux_tvalid[0]), 32'd0);
    check("pkt_sop_no_ready", 32'(afu_tready[0]), 32'd0);
    check("pkt_hold_start", 32'(prst_n[0]), 32'd0);
    tvalid[0] = 1'b0;
    repeat (16) tick();
    check("pkt_done", 32'(done), 32'b0001);
    repeat (2) tick();

    // Simultaneous requests on ports 0 and 3
    req = 4'b1001;
    tick();
    req = '0;
    check("dual_rst_t1", 32'(prst_n), 32'(4'b0110));
    repeat (16) tick();
    check("dual_done_t17", 32'(done), 32'(4'b1001));
    check("dual_rst_t17", 32'(prst_n), 32'(4'hf));
    repeat (2) tick();

    // Level request held 40 cycles on port 2
    first = -1; second = -1; third = -1;
    req[2] = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 40) req[2] = 1'b0;
      if (done[2]) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
        else if (third < 0) third = i;
      end
    end
    check("level_first_done", 32'(first), 32'd17);
    check("level_second_done", 32'(second), 32'd34);
    check("level_third_done", 32'(third), 32'd51);

    // Idle pass-through honours downstream backpressure
    tvalid[3] = 1'b1; tlast[3] = 1'b1; mux_tready[3] = 1'b0;
    #1;
    check("idle_bp_ready", 32'(afu_tready[3]), 32'd0);
    check("idle_bp_valid", 32'(mux_tvalid[3]), 32'd1);
    tick();
    mux_tready[3] = 1'b1;
    tick();
    tvalid[3] = 1'b0; tlast[3] = 1'b0;
    tick();

`ifdef AFU_PORT_FLR_TIMEOUT_EN
    // Drain watchdog on port 1 with tvalid stuck low
    tvalid[1] = 1'b1;
    tick();
    tvalid[1] = 1'b0;
    req[1] = 1'b1;
    tick();
    req = '0;
    repeat (7) tick();
    check("to_still_drain", 32'(prst_n[1]), 32'd1);
    tick();
    check("to_hold_start", 32'(prst_n[1]), 32'd0);
    check("to_err_set", 32'(err), 32'(4'b0010));
    repeat (20) tick();
    check("to_err_sticky", 32'(err), 32'(4'b0010));
`else
    check("no_timeout_err", 32'(err), 32'(4'h0));
`endif

    // Async reset mid-sequence on port 1
    req[1] = 1'b1;
    tick();
    req = '0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("areset_rst_n", 32'(prst_n), 32'(4'h0));
    check("areset_done", 32'(done), 32'(4'h0));
    check("areset_err", 32'(err), 32'(4'h0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("areset_por_cyc15", 32'(prst_n), 32'(4'h0));
    tick();
    check("areset_por_done", 32'(prst_n), 32'(4'hf));
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
